// File: rtl/running_sum_pkg.sv
// Definitions shared by generator stages: data width, data type and stage states.
package running_sum_pkg;
   localparam int DATA_W = 32;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      DONE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2
   } gen_state_e;
endpackage

// File: rtl/running_sum_if.sv
// Downstream valid/ready stream carrying one two-field tuple per transfer.
interface running_sum_if;
   import running_sum_pkg::*;

   data_t data0;
   data_t data1;
   logic  valid;
   logic  ready;

   modport master (output data0, output data1, output valid, input ready);
   modport slave  (input data0, input data1, input valid, output ready);
endinterface

// File: rtl/running_sum_stream_hold.sv
// Output hold register for a generator stage: keeps a tuple stable until taken downstream.
module stream_hold
   import running_sum_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          load_i,
   input  data_t         data0_i,
   input  data_t         data1_i,
   output logic          advance_o,
   output logic          handshake_o,
   running_sum_if.master out_bus
);
   logic  valid_q;
   data_t data0_q;
   data_t data1_q;

   assign handshake_o   = valid_q && out_bus.ready;
   assign advance_o     = out_bus.ready || !valid_q;
   assign out_bus.valid = valid_q;
   assign out_bus.data0 = data0_q;
   assign out_bus.data1 = data1_q;

   // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data0_q <= data0_i;
         data1_q <= data1_i;
      end else if (handshake_o) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/running_sum.sv
// Generator stage: accumulates upstream values and yields (sum, count) when the key passes YIELD_MIN.
module running_sum
   import running_sum_pkg::*;
#(
   parameter int YIELD_MIN = 0
) (
   input  logic  _clock,
   input  logic  _reset,
   input  logic  _start,
   input  data_t in_0,
   input  data_t in_1,
   input  logic  _in_valid,
   input  logic  _in_done,
   output logic  _in_ready,
   input  logic  _ready,
   output logic  _valid,
   output logic  _done,
   output data_t _out_0,
   output data_t _out_1
);
   gen_state_e state_q, state_d;
   data_t      sum_q, sum_d;
   data_t      count_q, count_d;
   logic       in_ready_q, in_ready_d;
   logic       done_q, done_d;
   logic       load, advance, handshake, transfer;

   running_sum_if hold_bus ();

   stream_hold u_hold (
      .clk         (_clock),
      .rst_n       (_reset),
      .clear_i     (_start),
      .load_i      (load),
      .data0_i     (sum_d),
      .data1_i     (count_d),
      .advance_o   (advance),
      .handshake_o (handshake),
      .out_bus     (hold_bus)
   );

   assign hold_bus.ready = _ready;
   assign _valid         = hold_bus.valid;
   assign _out_0         = hold_bus.data0;
   assign _out_1         = hold_bus.data1;
   assign _in_ready      = in_ready_q;
   assign _done          = done_q;

   assign transfer = in_ready_q && _in_valid && advance;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      count_d = count_q;
      load    = 1'b0;
      if (_start) begin
         state_d = FETCH;
         sum_d   = '0;
         count_d = '0;
      end else begin
         case (state_q)
            FETCH: begin
               // A tuple presented together with _in_done is consumed before done is honoured.
               if (transfer) begin
                  sum_d   = sum_q + in_0;
                  count_d = count_q + 1;
                  if (in_1 >= YIELD_MIN) begin
                     load    = 1'b1;
                     state_d = EMIT;
                  end
               end else if (_in_done && advance) begin
                  state_d = DONE;
               end
            end
            EMIT:    if (handshake) state_d = FETCH;
            default: ;
         endcase
      end
      in_ready_d = (state_d == FETCH);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge _clock) begin
      if (!_reset) begin
         state_q    <= DONE;
         sum_q      <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
      end
   end
endmodule

// File: tb/tb_running_sum.sv
// Scoreboard bench: two running_sum instances (YIELD_MIN 0 and 5) against a tuple-level model.
module tb_running_sum;
   localparam int YM0 = 0;
   localparam int YM1 = 5;

   typedef struct {
      int s;
      int c;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_r = 1'b0;
   logic              start_r    [2];
   logic              in_valid_r [2];
   logic              in_done_r  [2];
   logic signed [31:0] in0_r     [2];
   logic signed [31:0] in1_r     [2];
   logic              ready_r    [2];
   logic              in_ready_w [2];
   logic              done_w     [2];
   logic              valid_w    [2];
   logic signed [31:0] out0_w    [2];
   logic signed [31:0] out1_w    [2];

   int   rdy_mode [2];
   int   m_sum    [2];
   int   m_cnt    [2];
   exp_t exp_q0 [$];
   exp_t exp_q1 [$];

   logic              stall_q [2];
   logic signed [31:0] prev0  [2];
   logic signed [31:0] prev1  [2];

   int n_checks = 0;
   int n_errors = 0;

   running_sum_if bus0 ();
   running_sum_if bus1 ();

   always #5 clk = ~clk;

   running_sum #(.YIELD_MIN(YM0)) dut0 (
      ._clock(clk), ._reset(reset_r), ._start(start_r[0]),
      .in_0(in0_r[0]), .in_1(in1_r[0]), ._in_valid(in_valid_r[0]), ._in_done(in_done_r[0]),
      ._in_ready(in_ready_w[0]), ._ready(ready_r[0]), ._valid(valid_w[0]), ._done(done_w[0]),
      ._out_0(out0_w[0]), ._out_1(out1_w[0])
   );

   running_sum #(.YIELD_MIN(YM1)) dut1 (
      ._clock(clk), ._reset(reset_r), ._start(start_r[1]),
      .in_0(in0_r[1]), .in_1(in1_r[1]), ._in_valid(in_valid_r[1]), ._in_done(in_done_r[1]),
      ._in_ready(in_ready_w[1]), ._ready(ready_r[1]), ._valid(valid_w[1]), ._done(done_w[1]),
      ._out_0(out0_w[1]), ._out_1(out1_w[1])
   );

   assign bus0.valid = valid_w[0];
   assign bus0.data0 = out0_w[0];
   assign bus0.data1 = out1_w[0];
   assign bus0.ready = ready_r[0];
   assign bus1.valid = valid_w[1];
   assign bus1.data0 = out0_w[1];
   assign bus1.data1 = out1_w[1];
   assign bus1.ready = ready_r[1];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
   always begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++)
         ready_r[i] = (rdy_mode[i] == 0) ? 1'b1 :
                      (rdy_mode[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // Reference model: each accepted tuple adds to the sum, bumps the count, and yields if the key passes.
   task automatic model_accept(input int idx, input int a, input int b);
      m_sum[idx] += a;
      m_cnt[idx] += 1;
      if (b >= ((idx == 0) ? YM0 : YM1)) begin
         if (idx == 0) exp_q0.push_back('{m_sum[idx], m_cnt[idx]});
         else          exp_q1.push_back('{m_sum[idx], m_cnt[idx]});
      end
   endtask

   task automatic mon_step(input int idx, input logic v, input logic r,
                           input logic signed [31:0] d0, input logic signed [31:0] d1,
                           input logic ir);
      exp_t e;
      int   sz;
      if (stall_q[idx]) begin
         check("hold_valid", v, 1);
         check("hold_out0", d0, prev0[idx]);
         check("hold_out1", d1, prev1[idx]);
      end
      if (v) check("in_ready_in_emit", ir, 0);
      if (v && r) begin
         sz = (idx == 0) ? exp_q0.size() : exp_q1.size();
         if (sz == 0) begin
            check("extra_output", sz, 1);
         end else begin
            if (idx == 0) e = exp_q0.pop_front();
            else          e = exp_q1.pop_front();
            check("out_0", d0, e.s);
            check("out_1", d1, e.c);
         end
      end
      stall_q[idx] = v && !r && reset_r;
      prev0[idx]   = d0;
      prev1[idx]   = d1;
   endtask

   always @(negedge clk) begin
      mon_step(0, bus0.valid, bus0.ready, bus0.data0, bus0.data1, in_ready_w[0]);
      mon_step(1, bus1.valid, bus1.ready, bus1.data0, bus1.data1, in_ready_w[1]);
   end

   task automatic start(input int idx);
      start_r[idx] = 1'b1;
      tick();
      start_r[idx] = 1'b0;
      m_sum[idx] = 0;
      m_cnt[idx] = 0;
   endtask

   task automatic send(input int idx, input int a, input int b, input logic last);
      logic got = 1'b0;
      in0_r[idx]      = a;
      in1_r[idx]      = b;
      in_valid_r[idx] = 1'b1;
      in_done_r[idx]  = last;
      for (int k = 0; k < 200; k++) begin
         if (in_ready_w[idx]) begin
            got = 1'b1;
            model_accept(idx, a, b);
         end
         tick();
         if (got) break;
      end
      in_valid_r[idx] = 1'b0;
      if (!got) check("send_timeout", got, 1);
   endtask

   task automatic end_stream(input int idx);
      in_done_r[idx] = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (done_w[idx]) break;
         tick();
      end
      check("done_reached", done_w[idx], 1);
      check("drained", (idx == 0) ? exp_q0.size() : exp_q1.size(), 0);
      in_done_r[idx] = 1'b0;
   endtask

   task automatic spec_stream(input int idx);
      start(idx);
      for (int n = 0; n < 5; n++) send(idx, 2 * n, 2 * n, 1'b0);
      end_stream(idx);
   endtask

   task automatic random_stream(input int idx, input int len);
      start(idx);
      for (int n = 0; n < len; n++)
         send(idx, int'($urandom), int'($urandom_range(0, 30)) - 10, n == len - 1);
      end_stream(idx);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_r[i] = 0; in_valid_r[i] = 0; in_done_r[i] = 0;
         in0_r[i] = 0; in1_r[i] = 0; ready_r[i] = 1; rdy_mode[i] = 0;
         m_sum[i] = 0; m_cnt[i] = 0; stall_q[i] = 0; prev0[i] = 0; prev1[i] = 0;
      end
      start_r[0] = 1'b1;
      repeat (3) tick();
      start_r[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", valid_w[i], 0);
         check("rst_done", done_w[i], 0);
         check("rst_in_ready", in_ready_w[i], 0);
         check("rst_out_0", out0_w[i], 0);
         check("rst_out_1", out1_w[i], 0);
      end
      reset_r = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) check("done_after_reset", done_w[i], 1);

      // Fixed stream on both yield thresholds, then random downstream back-pressure.
      spec_stream(0);
      rdy_mode[1] = 1;
      spec_stream(1);

      // Stall in EMIT while a second tuple is waiting upstream.
      rdy_mode[0] = 2;
      start(0);
      send(0, 3, 1, 1'b0);
      fork
         send(0, 4, 1, 1'b0);
         begin
            repeat (3) tick();
            rdy_mode[0] = 0;
         end
      join
      end_stream(0);

      // Signed wrap of the accumulator.
      start(0);
      send(0, 32'h7FFF_FFFF, 0, 1'b0);
      send(0, 1, 0, 1'b0);
      end_stream(0);

      rdy_mode[0] = 1;
      random_stream(0, 30);
      random_stream(1, 30);
      rdy_mode[0] = 0;

      // Upstream exhausted on the very first FETCH cycle.
      start_r[0] = 1'b1;
      tick();
      start_r[0] = 1'b0;
      check("first_fetch_ready", in_ready_w[0], 1);
      in_done_r[0] = 1'b1;
      tick();
      check("early_done", done_w[0], 1);
      check("early_no_valid", valid_w[0], 0);
      in_done_r[0] = 1'b0;

      // Reset (with _start) while an output is pending, then a clean restart.
      rdy_mode[0] = 2;
      start(0);
      send(0, 9, 1, 1'b0);
      tick();
      check("pending_valid", valid_w[0], 1);
      reset_r    = 1'b0;
      start_r[0] = 1'b1;
      tick();
      check("rst_emit_valid", valid_w[0], 0);
      check("rst_emit_in_ready", in_ready_w[0], 0);
      reset_r    = 1'b1;
      start_r[0] = 1'b0;
      exp_q0.delete();
      rdy_mode[0] = 0;
      tick();
      check("rst_emit_done", done_w[0], 1);
      start(0);
      send(0, 5, 1, 1'b0);
      end_stream(0);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
